apb_shared_master: RTL and testbench

APB_SHARED_MASTER -- requirements
Module: apb_shared_master

---
 rtl/apb_shared_pkg.sv | 15 +
 rtl/apb_rr_arbiter.sv | 27 ++
 rtl/apb_shared_master.sv | 146 ++++++++++++++
 tb/tb_apb_shared_master.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_shared_pkg.sv
// Shared types and defaults for the multi-requester APB master.
package apb_shared_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_NREQ       = 2;
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 32;
  localparam int TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module apb_rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  pick
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = PTR_W'((32'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_shared_master.sv
// APB master shared by NREQ requesters with round-robin arbitration.
// Optional ACCESS wait timeout enabled by APB_SHARED_MASTER_TIMEOUT_EN.
module apb_shared_master
  import apb_shared_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   Rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  input  logic [NREQ-1:0]        req_write,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [DATA_W-1:0]      rdata,
  output logic                   err,
  output logic [ADDR_W-1:0]      PAddr,
  output logic [DATA_W-1:0]      PWData,
  output logic                   PWrite,
  output logic                   PSel,
  output logic                   PEnable,
  input  logic [DATA_W-1:0]      PRData,
  input  logic                   PReady
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  apb_state_e       st, nxt;
  logic [PTR_W-1:0] ptr, own_idx, pick_idx, nxt_ptr;
  logic [NREQ-1:0]  pick, owner_oh;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic             sel_write;
  logic             grant, xfer_ok, timeout;

  apb_rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req  (req),
    .ptr  (ptr),
    .pick (pick)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    pick_idx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        pick_idx  = PTR_W'(i);
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_write = req_write[i];
      end
    end
  end

  always_comb begin
    owner_oh = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      owner_oh[i] = (own_idx == PTR_W'(i));
  end

  assign nxt_ptr = (own_idx == PTR_W'(NREQ-1)) ? '0 : own_idx + 1'b1;

  // No arbitration in the done cycle: the finished requester still shows its
  // req that cycle, and sampling it would start a transfer it never asked for.
  assign grant   = (st == IDLE) && (|pick) && !(|done);
  assign xfer_ok = (st == ACCESS) && PReady;

`ifdef APB_SHARED_MASTER_TIMEOUT_EN
  logic [4:0] wait_cnt;

  assign timeout = (st == ACCESS) && !PReady &&
                   (wait_cnt == 5'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk) begin
    if (Rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= timeout;
      if ((st == ACCESS) && !PReady && !timeout)
        wait_cnt <= wait_cnt + 5'd1;
      else
        wait_cnt <= '0;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (Rst) st <= IDLE;
    else     st <= nxt;
  end

  always_comb begin
    nxt = st;
    case (st)
      IDLE:    if (grant) nxt = SETUP;
      SETUP:   nxt = ACCESS;
      ACCESS:  if (xfer_ok || timeout) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    PSel    = (st == SETUP) || (st == ACCESS);
    PEnable = (st == ACCESS);
    gnt     = PSel ? owner_oh : '0;
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      ptr     <= '0;
      own_idx <= '0;
      PAddr   <= '0;
      PWData  <= '0;
      PWrite  <= 1'b0;
      done    <= '0;
      rdata   <= '0;
    end else begin
      done <= '0;
      if (grant) begin
        own_idx <= pick_idx;
        PAddr   <= sel_addr;
        PWData  <= sel_wdata;
        PWrite  <= sel_write;
      end
      if (xfer_ok || timeout) begin
        done <= owner_oh;
        ptr  <= nxt_ptr;
      end
      if (xfer_ok && !PWrite)
        rdata <= PRData;
    end
  end

endmodule

// File: tb/tb_apb_shared_master.sv
// Directed bench for apb_shared_master with a small APB memory slave.
module tb_apb_shared_master;

  logic        clk = 1'b0;
  logic        Rst;
  logic [1:0]  req;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_write;
  logic [1:0]  gnt, done;
  logic [31:0] rdata;
  logic        err;
  logic [15:0] PAddr;
  logic [31:0] PWData, PRData;
  logic        PWrite, PSel, PEnable, PReady;

  logic [31:0] mem [0:255];
  int n_vec = 0;
  int n_bad = 0;

  apb_shared_master #(
    .NREQ   (2),
    .ADDR_W (16),
    .DATA_W (32)
  ) dut (
    .clk       (clk),
    .Rst       (Rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_write (req_write),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .PAddr     (PAddr),
    .PWData    (PWData),
    .PWrite    (PWrite),
    .PSel      (PSel),
    .PEnable   (PEnable),
    .PRData    (PRData),
    .PReady    (PReady)
  );

  always #5 clk = ~clk;

  assign PRData = mem[PAddr[7:0]];

  always @(posedge clk) begin
    if (Rst)
      mem[8'h10] <= 32'hDEAD_BEEF;
    else if (PSel && PEnable && PReady && PWrite)
      mem[PAddr[7:0]] <= PWData;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] owners [4];
    int         cycs   [4];
    int         nd;
    int         n;
    logic [31:0] rd_before;

    Rst = 1'b1; req = '0; req_addr = '0; req_wdata = '0; req_write = '0; PReady = 1'b1;
    tick(); tick();
    check("rst_psel",  {PSel, PEnable}, 2'b00);
    check("rst_gnt",   gnt, 2'b00);
    check("rst_done",  {done, err}, 3'b000);
    check("rst_rdata", rdata, 32'h0);
    check("rst_bus",   {PAddr, PWData, PWrite}, 49'h0);
    Rst = 1'b0;

    // Write from requester 0
    req = 2'b01; req_addr = {16'h0, 16'h0050}; req_wdata = {32'h0, 32'h0000_0050}; req_write = 2'b01;
    tick();
    check("wr_setup_ctl", {PSel, PEnable, gnt}, 4'b1001);
    check("wr_setup_bus", {PAddr, PWData, PWrite}, {16'h0050, 32'h50, 1'b1});
    tick();
    check("wr_access", {PSel, PEnable, done}, 4'b1100);
    tick();
    check("wr_done", {done, PSel, PEnable}, 4'b0100);
    req = '0;
    check("wr_mem", mem[8'h50], 32'h50);
    tick();
    check("wr_hold", {PAddr, PWrite, done}, {16'h0050, 1'b1, 2'b00});

    // Read by requester 1
    req = 2'b10; req_addr = {16'h0010, 16'h0}; req_write = 2'b00;
    tick();
    check("rd_setup", {gnt, PAddr, PWrite}, {2'b10, 16'h0010, 1'b0});
    tick();
    check("rd_access", {PSel, PEnable}, 2'b11);
    tick();
    check("rd_done", done, 2'b10);
    check("rd_data", rdata, 32'hDEAD_BEEF);
    check("rd_err", err, 1'b0);
    req = '0;
    tick();
    check("rd_hold", {rdata, done}, {32'hDEAD_BEEF, 2'b00});

    // Wait states: requester 0 write, PReady low for three ACCESS cycles
    req = 2'b01; req_addr = {16'h0, 16'h0020}; req_wdata = {32'h0, 32'h0000_1234}; req_write = 2'b01;
    PReady = 1'b0;
    tick();
    check("ws_setup", {PSel, PEnable, gnt}, 4'b1001);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("ws_access%0d", k), {PSel, PEnable, done}, 4'b1100);
      check($sformatf("ws_bus%0d", k), {PAddr, PWData, PWrite}, {16'h0020, 32'h1234, 1'b1});
      if (k == 3) PReady = 1'b1;
    end
    tick();
    check("ws_done", {done, PEnable}, 3'b010);
    check("ws_mem", mem[8'h20], 32'h1234);
    req = '0;
    tick();

    // Reset mid-transfer; ptr is 1 here, so requester 1 wins first
    req = 2'b11; req_addr = {16'h0010, 16'h0030}; req_write = 2'b00; PReady = 1'b0;
    tick();
    check("mr_setup", gnt, 2'b10);
    tick();
    check("mr_access", {PSel, PEnable}, 2'b11);
    Rst = 1'b1;
    tick();
    check("mr_rst_bus", {PSel, PEnable, gnt, done}, 6'b0);
    check("mr_rst_rdata", rdata, 32'h0);
    Rst = 1'b0;
    req = 2'b01;
    tick();
    check("mr_first_gnt", gnt, 2'b01);
    PReady = 1'b1;
    tick();
    tick();
    check("mr_done", done, 2'b01);
    req = '0;

    // Contention from reset
    Rst = 1'b1;
    tick();
    req = 2'b11; req_addr = {16'h0044, 16'h0040}; req_wdata = {32'h11, 32'h22}; req_write = 2'b11;
    PReady = 1'b1;
    Rst = 1'b0;
    nd = 0;
    for (int c = 1; c <= 30 && nd < 4; c++) begin
      tick();
      if (done != 2'b00) begin
        owners[nd] = done;
        cycs[nd]   = c;
        nd++;
      end
    end
    req = '0;
    check("ct_count", nd, 4);
    if (nd == 4) begin
      check("ct_own0", owners[0], 2'b01);
      check("ct_own1", owners[1], 2'b10);
      check("ct_own2", owners[2], 2'b01);
      check("ct_own3", owners[3], 2'b10);
      check("ct_cyc0", cycs[0], 3);
      check("ct_gap1", cycs[1] - cycs[0], 4);
      check("ct_gap2", cycs[2] - cycs[1], 4);
      check("ct_gap3", cycs[3] - cycs[2], 4);
    end
    tick();

    // Slave never ready
    rd_before = rdata;
    req = 2'b01; req_addr = {16'h0, 16'h0010}; req_write = 2'b00; PReady = 1'b0;
`ifdef APB_SHARED_MASTER_TIMEOUT_EN
    n = 0;
    for (int c = 1; c <= 40 && n == 0; c++) begin
      tick();
      if (done != 2'b00) begin
        n = c;
        check("to_err", err, 1'b1);
        check("to_done", done, 2'b01);
        check("to_rdata", rdata, rd_before);
        check("to_idle", {PSel, PEnable}, 2'b00);
      end
    end
    check("to_latency", n, 18);
    req = '0;
    tick();
    check("to_err_pulse", {err, done}, 3'b000);
`else
    n = 0;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (done != 2'b00 || err != 1'b0) n++;
    end
    check("nt_no_done", n, 0);
    check("nt_waiting", {PSel, PEnable}, 2'b11);
    PReady = 1'b1;
    tick();
    check("nt_done", {done, err}, 3'b010);
    check("nt_rdata", rdata, 32'hDEAD_BEEF);
    req = '0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
